// File: rtl/mul_share_arb.sv
// Arbitrated front end sharing one 4x4 Wallace-tree multiplier among NREQ requesters.
// Define MUL_SHARE_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.

module waltree (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s1, c1, s2, c2;

    assign pp0 = {4'b0, a & {4{b[0]}}};
    assign pp1 = {3'b0, a & {4{b[1]}}, 1'b0};
    assign pp2 = {2'b0, a & {4{b[2]}}, 2'b0};
    assign pp3 = {1'b0, a & {4{b[3]}}, 3'b0};

    // Two 3:2 compressor layers reduce four rows to sum/carry, then one carry-propagate add.
    assign s1 = pp0 ^ pp1 ^ pp2;
    assign c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
    assign s2 = s1 ^ c1 ^ pp3;
    assign c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
    assign p  = s2 + c2;
endmodule

module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_p,
    output logic              busy,
    output logic [15:0]       op_cnt
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t          state, state_nxt;
    logic            grant;
    logic            any_valid;
    logic [NREQ-1:0] cand;
    logic [IDW-1:0]  win;
    logic [NREQ-1:0] win_oh;
    logic [3:0]      win_a, win_b;
    logic [3:0]      a_r, b_r;
    logic [IDW-1:0]  id_r;
    logic [7:0]      prod;
    logic [15:0]     op_cnt_q;
`ifdef MUL_SHARE_ARB_RR_EN
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] above;
`endif

    function automatic logic [IDW-1:0] first_set(input logic [NREQ-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = IDW'(i);
        end
        return r;
    endfunction

    // Winner selection: round-robin prefers indices above ptr, then wraps to the lowest valid.
    always_comb begin
        any_valid = |req_valid;
`ifdef MUL_SHARE_ARB_RR_EN
        above = '0;
        for (int i = 0; i < NREQ; i++) begin
            above[i] = (i > int'(ptr));
        end
        cand = (|(req_valid & above)) ? (req_valid & above) : req_valid;
`else
        cand = req_valid;
`endif
        win    = first_set(cand);
        win_oh = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_oh[i] = 1'b1;
                win_a     = req_a[4*i +: 4];
                win_b     = req_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    grant     = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    grant     = any_valid;
                    state_nxt = any_valid ? MUL : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is suppressed while reset is held so no requester sees a handshake during reset.
    assign req_ready = (grant && !rst) ? win_oh : '0;
    assign busy      = (state != IDLE);
    assign op_cnt    = op_cnt_q;

    waltree u_waltree (
        .a(a_r),
        .b(b_r),
        .p(prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            id_r      <= '0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            op_cnt_q  <= '0;
`ifdef MUL_SHARE_ARB_RR_EN
            ptr       <= IDW'(NREQ - 1);
`endif
        end else begin
            if (grant) begin
                a_r  <= win_a;
                b_r  <= win_b;
                id_r <= win;
`ifdef MUL_SHARE_ARB_RR_EN
                ptr  <= win;
`endif
            end
            if (state == MUL) begin
                rsp_p     <= prod;
                rsp_id    <= id_r;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_cnt_q  <= op_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb (expectations follow MUL_SHARE_ARB_RR_EN if defined).

module tb_mul_share_arb;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_p;
    logic        busy;
    logic [15:0] op_cnt;

    int n_checks;
    int n_fail;

    mul_share_arb #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy), .op_cnt(op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_a = 16'hFFFF; req_b = 16'hFFFF; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_no_grant: req_ready=%b want 0000", req_ready); end
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
        n_checks++;
        if ({rsp_p, rsp_id, op_cnt} !== 26'h0) begin n_fail++; $display("FAIL reset_data: rsp_p=%h rsp_id=%0d op_cnt=%h want 0", rsp_p, rsp_id, op_cnt); end
        req_valid = '0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_a[3:0] = 4'd15; req_b[3:0] = 4'd15; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0; req_a = '0; req_b = '0;
        #1;
        n_checks++;
        if ({busy, rsp_valid, req_ready} !== 6'b100000) begin n_fail++; $display("FAIL single_mul: busy=%b rsp_valid=%b req_ready=%b want 1 0 0000", busy, rsp_valid, req_ready); end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_p, rsp_id} !== {1'b1, 8'hE1, 2'd0}) begin n_fail++; $display("FAIL single_rsp: valid=%b p=%h id=%0d want 1 e1 0", rsp_valid, rsp_p, rsp_id); end
        @(negedge clk);
        n_checks++;
        if ({op_cnt, rsp_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL single_done: op_cnt=%0d valid=%b busy=%b want 1 0 0", op_cnt, rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int exp_g[6];
`ifdef MUL_SHARE_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0, 1};
`else
        exp_g = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i + 1);
            req_b[4*i +: 4] = 4'd3;
        end
        req_valid = 4'hF; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'(1 << exp_g[0])) begin n_fail++; $display("FAIL b2b_grant0: req_ready=%b want %b", req_ready, 4'(1 << exp_g[0])); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, req_ready} !== 5'b0) begin n_fail++; $display("FAIL b2b_mul%0d: valid=%b req_ready=%b want 0 0000", k, rsp_valid, req_ready); end
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_p, rsp_id} !== {1'b1, 8'((exp_g[k] + 1) * 3), 2'(exp_g[k])})
                begin n_fail++; $display("FAIL b2b_rsp%0d: valid=%b p=%0d id=%0d want 1 %0d %0d", k, rsp_valid, rsp_p, rsp_id, (exp_g[k] + 1) * 3, exp_g[k]); end
            if (k == 4) req_valid = '0;
            #1;
            n_checks++;
            if (req_ready !== ((k == 4) ? 4'b0 : 4'(1 << exp_g[k+1])))
                begin n_fail++; $display("FAIL b2b_grant%0d: req_ready=%b want %b", k + 1, req_ready, (k == 4) ? 4'b0 : 4'(1 << exp_g[k+1])); end
        end
        @(negedge clk);
        n_checks++;
        if ({op_cnt, busy} !== {16'd5, 1'b0}) begin n_fail++; $display("FAIL b2b_count: op_cnt=%0d busy=%b want 5 0", op_cnt, busy); end
    endtask

    task automatic test_backpressure();
        req_a = '0; req_b = '0;
        req_valid = 4'b0100; req_a[11:8] = 4'd9; req_b[11:8] = 4'd7; rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: req_ready=%b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010; req_a[11:8] = 4'd0; req_a[7:4] = 4'd2; req_b[7:4] = 4'd3;
        #1;
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_mul_ready: req_ready=%b want 0000", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_p, rsp_id, req_ready, busy} !== {1'b1, 8'd63, 2'd2, 4'b0, 1'b1})
                begin n_fail++; $display("FAIL bp_hold%0d: valid=%b p=%0d id=%0d req_ready=%b busy=%b want 1 63 2 0000 1", c, rsp_valid, rsp_p, rsp_id, req_ready, busy); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({rsp_p, req_ready} !== {8'd63, 4'b0010}) begin n_fail++; $display("FAIL bp_accept: p=%0d req_ready=%b want 63 0010", rsp_p, req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({rsp_valid, busy, op_cnt} !== {1'b0, 1'b1, 16'd6}) begin n_fail++; $display("FAIL bp_next_mul: valid=%b busy=%b op_cnt=%0d want 0 1 6", rsp_valid, busy, op_cnt); end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_p, rsp_id} !== {1'b1, 8'd6, 2'd1}) begin n_fail++; $display("FAIL bp_next_rsp: valid=%b p=%0d id=%0d want 1 6 1", rsp_valid, rsp_p, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        req_a = '0; req_b = '0;
        req_valid = 4'b0010; req_a[7:4] = 4'd5; req_b[7:4] = 4'd5; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rif_grant: req_ready=%b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rif_busy: busy=%b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_p, rsp_id, op_cnt, req_ready} !== 32'h0)
            begin n_fail++; $display("FAIL rif_async: valid=%b busy=%b p=%0d id=%0d op_cnt=%0d req_ready=%b want all 0", rsp_valid, busy, rsp_p, rsp_id, op_cnt, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, busy, rsp_p} !== 10'h0) begin n_fail++; $display("FAIL rif_discard%0d: valid=%b busy=%b p=%0d want 0 0 0", c, rsp_valid, busy, rsp_p); end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.op_cnt_q;
        n_checks++;
        if (op_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: op_cnt=%h want fffe", op_cnt); end
        req_a = '0; req_b = '0; req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            req_valid = 4'b0001;
            @(negedge clk);
            req_valid = '0;
            repeat (2) @(negedge clk);
            n_checks++;
            if (op_cnt !== ((t == 0) ? 16'hFFFF : 16'h0000))
                begin n_fail++; $display("FAIL wrap_cnt%0d: op_cnt=%h want %h", t, op_cnt, (t == 0) ? 16'hFFFF : 16'h0000); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
